button_conditioner: RTL
=======================

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter NUM_BTN, default 5: number of independent button channels.
REQ-002 Parameter DEBOUNCE_CYCLES, default 500000: consecutive stable cycles required to accept a level change (10 ms at 50 MHz); legal range 2..2^24-1.
REQ-003 Parameter REPEAT_DELAY, default 25000000: held cycles before the first auto-repeat pulse (used only with BTN_AUTOREPEAT_EN).
REQ-004 Parameter REPEAT_PERIOD, default 5000000: cycles between subsequent auto-repeat pulses (used only with BTN_AUTOREPEAT_EN).
REQ-005 clk  input  1  system clock, all logic rising-edge.
REQ-006 rst  input  1  synchronous reset, active-high.
REQ-007 btn_raw  input  NUM_BTN  asynchronous, bouncing pushbutton levels, 1 = pressed.
REQ-008 btn_db  output  NUM_BTN  debounced level; drives the downstream LED-cycle stage buttons input.
REQ-009 btn_press  output  NUM_BTN  one-cycle pulse per accepted press (and per auto-repeat).
REQ-010 btn_release  output  NUM_BTN  one-cycle pulse per accepted release.

Function
REQ-011 Each btn_raw bit SHALL pass through a 2-flop synchroniser (s1, s2) before any other use; channels are fully independent.
REQ-012 Per channel, a counter SHALL clear on every cycle where s2 equals btn_db, and increment on every cycle where s2 differs from btn_db.
REQ-013 When the counter equals DEBOUNCE_CYCLES-1 and s2 still differs, btn_db SHALL take s2 on that edge and the counter SHALL clear; counter never exceeds DEBOUNCE_CYCLES-1.
REQ-014 Any single cycle of s2 equal to btn_db (bounce) SHALL restart the count from zero.
REQ-015 Latency: a clean raw edge SHALL appear on btn_db exactly DEBOUNCE_CYCLES+2 clock edges after the first edge sampling the new level.
REQ-016 btn_press[i] SHALL be high for exactly the first cycle in which btn_db[i] is 1 after being 0; btn_release[i] likewise for 1->0; both registered, never high together for one channel.
REQ-017 Simultaneous changes on several channels SHALL produce simultaneous, independent pulses.
REQ-018 A raw pulse shorter than DEBOUNCE_CYCLES cycles SHALL produce no change on any output.

Reset
REQ-019 While rst is high at a clock edge: s1, s2, btn_db, btn_press, btn_release, all counters and repeat state SHALL be 0/IDLE on the next edge.
REQ-020 Reset asserted mid-debounce or mid-repeat SHALL abort it without emitting any pulse; after release a button held throughout SHALL be accepted as a new press after DEBOUNCE_CYCLES+2 cycles.

Configuration
REQ-021 Macro BTN_AUTOREPEAT_EN SHALL compile in a per-channel auto-repeat FSM; when undefined, no repeat logic or counters exist and btn_press pulses only per REQ-016.
REQ-022 With BTN_AUTOREPEAT_EN, FSM states: IDLE -> DELAY on accepted press; DELAY -> REPEAT after REPEAT_DELAY cycles with btn_db held, emitting one btn_press pulse; REPEAT emits one pulse every REPEAT_PERIOD cycles; any state -> IDLE on btn_db = 0 in the same cycle, with no repeat pulse on that cycle.
REQ-023 With BTN_AUTOREPEAT_EN, a repeat pulse SHALL never coincide with a btn_release pulse on the same channel.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3 for bench)
REQ-024 Reset, btn_raw=00000 held 20 cycles -> btn_db=00000, no pulses at any time.
REQ-025 btn_raw[0] 0->1 held 10 cycles -> btn_db[0] rises 6 edges after first sampled high; btn_press[0] high exactly 1 cycle; release symmetric with btn_release[0].
REQ-026 btn_raw[2] bounces 1,0,1,1,0,1 then held 1 -> no output until 4 consecutive sampled highs, then a single btn_press[2].
REQ-027 btn_raw = 10001 same cycle, held -> btn_press=10001 in one cycle, btn_db=10001.
REQ-028 rst pulsed high 1 cycle at count 3 of a press -> no pulse, btn_db stays 0; press accepted 6 cycles after rst falls.
REQ-029 BTN_AUTOREPEAT_EN defined, btn_raw[1] held 30 cycles -> initial press pulse, repeat pulse 10 cycles later, then every 3 cycles; release -> one btn_release[1], no further pulses.

Source files
------------

// File: rtl/button_conditioner.sv
// button_conditioner
//   Multi-channel pushbutton front end. For each channel it synchronises the
//   raw level, debounces it, and emits one-cycle press and release pulses.
//
//   Optional feature macro: BTN_AUTOREPEAT_EN
//     When this macro is defined, a per-channel auto-repeat FSM is compiled in.
//     While a button stays held, this FSM emits extra btn_press pulses.
//     When the macro is undefined, no repeat state or timers exist, and
//     btn_press pulses only on accepted presses.
//
//   Auto-repeat FSM (one instance per channel, BTN_AUTOREPEAT_EN only)
//     state      | meaning
//     -----------+--------------------------------------------------------
//     RPT_IDLE   | button released, or press not yet accepted
//     RPT_DELAY  | press accepted, counting down REPEAT_DELAY to first repeat
//     RPT_REPEAT | repeating, counting down REPEAT_PERIOD between pulses
module button_conditioner #(
  parameter int NUM_BTN         = 5,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_db,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release
);

  // The counter only ever reaches DEBOUNCE_CYCLES-1, so clog2 of the
  // cycle count gives enough bits.
  localparam int              CNT_W    = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Reject parameter values that the counters cannot represent.
  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 16777215 ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
    $error("button_conditioner: parameter out of range");
  end

  logic [NUM_BTN-1:0]            sync_s1;
  logic [NUM_BTN-1:0]            sync_s2;
  logic [NUM_BTN-1:0][CNT_W-1:0] db_cnt;
  logic [NUM_BTN-1:0][CNT_W-1:0] db_cnt_next;
  logic [NUM_BTN-1:0]            db_next;
  logic [NUM_BTN-1:0]            db_rise;
  logic [NUM_BTN-1:0]            db_fall;

  // Two-flop synchroniser for the asynchronous button levels.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_s1 <= '0;
      sync_s2 <= '0;
    end else begin
      sync_s1 <= btn_raw;
      sync_s2 <= sync_s1;
    end
  end

  // Debounce decision. Any cycle that agrees with the accepted level
  // restarts the count. After DEBOUNCE_CYCLES disagreeing cycles in a row,
  // the new level is accepted.
  always_comb begin
    db_next     = btn_db;
    db_cnt_next = db_cnt;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (sync_s2[i] == btn_db[i]) begin
        db_cnt_next[i] = '0;
      end else if (db_cnt[i] == CNT_LAST) begin
        db_next[i]     = sync_s2[i];
        db_cnt_next[i] = '0;
      end else begin
        db_cnt_next[i] = db_cnt[i] + 1'b1;
      end
    end
  end

  assign db_rise = db_next & ~btn_db;
  assign db_fall = ~db_next & btn_db;

  // Debounced level and per-channel stability counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_db <= '0;
      db_cnt <= '0;
    end else begin
      btn_db <= db_next;
      db_cnt <= db_cnt_next;
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = (RPT_MAX > 2) ? $clog2(RPT_MAX) : 1;

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_t;

  rpt_state_t                    rpt_state [NUM_BTN];
  logic [NUM_BTN-1:0][RPT_W-1:0] rpt_timer;
  logic [NUM_BTN-1:0]            rpt_fire;

  // A repeat pulse fires when the down-counter expires. It is gated by
  // db_next, so a release on the same edge wins and no pulse is emitted.
  always_comb begin
    rpt_fire = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      rpt_fire[i] = (rpt_state[i] != RPT_IDLE) && db_next[i] && (rpt_timer[i] == '0);
    end
  end

  // Per-channel auto-repeat FSM with terminal-count down-counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_BTN; i++) begin
        rpt_state[i] <= RPT_IDLE;
      end
      rpt_timer <= '0;
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        case (rpt_state[i])
          RPT_IDLE: begin
            if (db_rise[i]) begin
              rpt_state[i] <= RPT_DELAY;
              rpt_timer[i] <= RPT_W'(REPEAT_DELAY - 1);
            end
          end
          RPT_DELAY, RPT_REPEAT: begin
            if (!db_next[i]) begin
              rpt_state[i] <= RPT_IDLE;
              rpt_timer[i] <= '0;
            end else if (rpt_timer[i] == '0) begin
              rpt_state[i] <= RPT_REPEAT;
              rpt_timer[i] <= RPT_W'(REPEAT_PERIOD - 1);
            end else begin
              rpt_timer[i] <= rpt_timer[i] - 1'b1;
            end
          end
          default: begin
            rpt_state[i] <= RPT_IDLE;
            rpt_timer[i] <= '0;
          end
        endcase
      end
    end
  end
`endif

  // Registered edge pulses. The pulses line up with the first cycle of the
  // new debounced level.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_press   <= '0;
      btn_release <= '0;
    end else begin
`ifdef BTN_AUTOREPEAT_EN
      btn_press   <= db_rise | rpt_fire;
`else
      btn_press   <= db_rise;
`endif
      btn_release <= db_fall;
    end
  end

endmodule
